// File: rtl/imm_encoder.sv
// Immediate packer for the program loader: scatters a sign-extended immediate
// into the RV32I I/S/B/J fields of a base word, range-checks it, and buffers one word.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [1:0]  src,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInstr,
    output logic [31:0] outAddr,
    output logic        outErr,
    output logic        errSticky,
    output logic [15:0] count
);

    // state | meaning
    // EMPTY | output register holds no word, outValid=0
    // FULL  | output register holds a word awaiting outReady, outValid=1
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nxt;
    logic        in_hs, out_hs;
    logic [31:0] packed_instr;
    logic        pack_err;

    assign outValid = (state == FULL);
    assign inReady  = !outValid || outReady;
    assign in_hs    = inValid && inReady;
    assign out_hs   = outValid && outReady;

    always_comb begin
        packed_instr = base;
        case (src)
            2'b00: packed_instr[31:20] = imm[11:0];
            2'b01: begin
                packed_instr[31:25] = imm[11:5];
                packed_instr[11:7]  = imm[4:0];
            end
            2'b10: begin
                packed_instr[31]    = imm[12];
                packed_instr[30:25] = imm[10:5];
                packed_instr[11:8]  = imm[4:1];
                packed_instr[7]     = imm[11];
            end
            default: begin
                packed_instr[31]    = imm[20];
                packed_instr[30:21] = imm[10:1];
                packed_instr[20]    = imm[11];
                packed_instr[19:12] = imm[19:12];
            end
        endcase
    end

    // In range exactly when every bit above the field's sign bit copies it.
    always_comb begin
        pack_err = 1'b0;
        case (src)
            2'b00, 2'b01: pack_err = (imm[31:11] != {21{imm[11]}});
            2'b10:        pack_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            default:      pack_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_hs) state_nxt = FULL;
            FULL:    if (out_hs && !in_hs) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            outInstr  <= 32'h0;
            outErr    <= 1'b0;
            outAddr   <= BASE_ADDR;
            errSticky <= 1'b0;
            count     <= 16'h0;
        end else begin
            state <= state_nxt;
            if (in_hs) begin
                outInstr <= packed_instr;
                outErr   <= pack_err;
                if (pack_err) errSticky <= 1'b1;
            end
            if (out_hs) begin
                outAddr <= outAddr + 32'd4;
                count   <= count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: bit-map packing model, scoreboard queue, SE round trip,
// directed literal vectors and randomized traffic with random backpressure.
module tb_imm_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [1:0]  src = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] base = 32'h0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outInstr;
    logic [31:0] outAddr;
    logic        outErr;
    logic        errSticky;
    logic [15:0] count;

    imm_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .src(src), .imm(imm), .base(base), .outValid(outValid),
        .outReady(outReady), .outInstr(outInstr), .outAddr(outAddr),
        .outErr(outErr), .errSticky(errSticky), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  s;
        logic [31:0] im;
        logic [31:0] instr;
        logic        err;
        bit          has_lit;
        logic [31:0] lit_instr;
        logic        lit_err;
        bit          has_addr;
        logic [31:0] lit_addr;
    } word_t;

    word_t       q[$];
    logic [31:0] m_addr;
    logic [15:0] m_count;
    logic        m_sticky;

    bit          cur_hl = 0, cur_ha = 0;
    logic [31:0] cur_li = 0, cur_la = 0;
    logic        cur_le = 0;
    bit          rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which immediate bit lands in instruction bit p, or -1 if p keeps base.
    function automatic int imm_bit(input logic [1:0] f, input int p);
        case (f)
            2'b00: return (p >= 20) ? p - 20 : -1;
            2'b01: return (p >= 25) ? p - 20 : (p >= 7 && p <= 11) ? p - 7 : -1;
            2'b10: return (p == 31) ? 12 : (p >= 25) ? p - 20 :
                          (p >= 8 && p <= 11) ? p - 7 : (p == 7) ? 11 : -1;
            default: return (p == 31) ? 20 : (p >= 21) ? p - 20 :
                            (p == 20) ? 11 : (p >= 12) ? p : -1;
        endcase
    endfunction

    function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [31:0] im, input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int p = 0; p < 32; p++) begin
            int k;
            k = imm_bit(f, p);
            if (k >= 0) r[p] = im[k];
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [1:0] f, input logic [31:0] im);
        longint v, lo, hi;
        v = longint'($signed(im));
        case (f)
            2'b00, 2'b01: begin lo = -2048;    hi = 2047;    end
            2'b10:        begin lo = -4096;    hi = 4094;    end
            default:      begin lo = -1048576; hi = 1048574; end
        endcase
        return (v < lo) || (v > hi) || (f[1] && im[0]);
    endfunction

    function automatic logic [31:0] se(input logic [31:0] i, input logic [1:0] f);
        case (f)
            2'b00: return {{20{i[31]}}, i[31:20]};
            2'b01: return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Compare process: outputs are stable at the falling edge; afterwards the
    // model is advanced to the state the next rising edge must produce.
    always @(negedge clk) begin
        bit in_hs, out_hs;
        word_t w;
        if (rst) begin
            q.delete();
            m_addr   = BASE;
            m_count  = 16'h0;
            m_sticky = 1'b0;
        end else begin
            chk("outValid", outValid, q.size() != 0);
            chk("inReady", inReady, (q.size() == 0) || outReady);
            chk("outAddr", outAddr, m_addr);
            chk("count", count, m_count);
            chk("errSticky", errSticky, m_sticky);
            if (q.size() != 0) begin
                chk("outInstr", outInstr, q[0].instr);
                chk("outErr", outErr, q[0].err);
            end
            out_hs = (q.size() != 0) && outReady;
            in_hs  = inValid && ((q.size() == 0) || outReady);
            if (out_hs) begin
                if (q[0].has_lit) begin
                    chk("lit_instr", outInstr, q[0].lit_instr);
                    chk("lit_err", outErr, q[0].lit_err);
                end
                if (q[0].has_addr) chk("lit_addr", outAddr, q[0].lit_addr);
                if (!q[0].err) chk("roundtrip", se(outInstr, q[0].s), q[0].im);
                void'(q.pop_front());
                m_addr  = m_addr + 32'd4;
                m_count = m_count + 16'd1;
            end
            if (in_hs) begin
                w.s = src; w.im = imm;
                w.instr = model_pack(src, imm, base);
                w.err = model_err(src, imm);
                w.has_lit = cur_hl; w.lit_instr = cur_li; w.lit_err = cur_le;
                w.has_addr = cur_ha; w.lit_addr = cur_la;
                q.push_back(w);
                if (w.err) m_sticky = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) outReady = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [1:0] s, input logic [31:0] im, input logic [31:0] b,
                        input bit hl, input logic [31:0] li, input logic le,
                        input bit ha, input logic [31:0] la, output int cyc);
        bit hs;
        src = s; imm = im; base = b;
        cur_hl = hl; cur_li = li; cur_le = le; cur_ha = ha; cur_la = la;
        inValid = 1'b1;
        cyc = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            hs = inReady;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                inValid = 1'b0;
                return;
            end
        end
        inValid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: got no handshake expected one within 500 cycles");
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [1:0] s;
        int v;
        logic [31:0] im;

        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_inReady", inReady, 1'b1);
        chk("rst_outAddr", outAddr, BASE);
        chk("rst_count", count, 16'h0);
        chk("rst_outInstr", outInstr, 32'h0);
        tick();

        // Directed vectors, consumer always ready
        outReady = 1'b1;
        send(2'b00, 32'hFFFF_FA75, 32'h0, 1, 32'hA750_0000, 1'b0, 1, BASE, cyc);
        send(2'b01, 32'hFFFF_FA75, 32'h0000_0A80, 1, 32'hA600_0A80, 1'b0, 1, BASE + 32'd4, cyc);
        chk("b2b_S_cycles", cyc, 1);
        send(2'b10, 32'hFFFF_FA74, 32'h0000_0A80, 1, 32'hA600_0A80, 1'b0, 1, BASE + 32'd8, cyc);
        chk("b2b_B_cycles", cyc, 1);
        send(2'b11, 32'hFFF0_0260, 32'h0000_0A80, 1, 32'hA600_0A80, 1'b0, 1, BASE + 32'd12, cyc);
        chk("b2b_J_cycles", cyc, 1);
        tick();
        chk("count_after_4", count, 16'd4);
        chk("sticky_clean", errSticky, 1'b0);

        // Error words
        send(2'b00, 32'h0000_0800, 32'h0, 1, 32'h8000_0000, 1'b1, 0, 0, cyc);
        tick();
        chk("sticky_I", errSticky, 1'b1);
        send(2'b10, 32'h0000_0003, 32'h0, 1, 32'h0000_0100, 1'b1, 0, 0, cyc);
        send(2'b11, 32'h0010_0000, 32'h0, 1, 32'h8000_0000, 1'b1, 0, 0, cyc);
        tick();
        chk("sticky_J", errSticky, 1'b1);

        // Backpressure: second word waits while the first is held
        outReady = 1'b0;
        send(2'b00, 32'h0000_0123, 32'h0000_0013, 1, 32'h1230_0013, 1'b0, 0, 0, cyc);
        src = 2'b01; imm = 32'h0000_0045; base = 32'h0000_0023;
        cur_hl = 1; cur_li = 32'h0400_02A3; cur_le = 1'b0; cur_ha = 0;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inReady", inReady, 1'b0);
            chk("bp_outInstr", outInstr, 32'h1230_0013);
            tick();
        end
        outReady = 1'b1;
        send(2'b01, 32'h0000_0045, 32'h0000_0023, 1, 32'h0400_02A3, 1'b0, 0, 0, cyc);
        tick();

        // Reset while FULL
        outReady = 1'b0;
        send(2'b00, 32'h0000_0001, 32'h0, 0, 0, 0, 0, 0, cyc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstfull_outValid", outValid, 1'b0);
        chk("rstfull_count", count, 16'h0);
        chk("rstfull_outAddr", outAddr, BASE);
        chk("rstfull_errSticky", errSticky, 1'b0);
        tick();

        // Random traffic: in-range round trips, then unconstrained immediates
        rand_ready = 1;
        for (int i = 0; i < 1200; i++) begin
            s = 2'($urandom_range(0, 3));
            case (s)
                2'b00, 2'b01: v = int'($urandom_range(0, 4095)) - 2048;
                2'b10:        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
                default:      v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            endcase
            im = 32'(v);
            if (i >= 1000) im = $urandom;
            send(s, im, $urandom, 0, 0, 0, 0, 0, cyc);
            if ($urandom_range(0, 4) == 0) tick();
        end

        rand_ready = 0;
        #2;
        outReady = 1'b1;
        for (int t = 0; t < 20 && q.size() != 0; t++) tick();
        chk("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
